// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the controller state encoding, register-address width, the
// architectural zero register, and the packed pipeline-control bundle.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } ctrl_state_e;

  // One bit per pipeline control line driven by the controller.
  typedef struct packed {
    logic multdiv_start;
    logic pc_stall;
    logic fetch_decode_stall;
    logic fetch_decode_flush;
    logic decode_execute_stall;
    logic decode_execute_flush;
    logic execute_memory_bubble;
  } ctrl_bus_t;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard compare.
// Flags when the instruction in execute is a load writing a non-zero
// register that the instruction in decode reads (rs always, rt only when
// decode_uses_rt is set).
// Ports:
//   decode_rs_address / decode_rt_address / decode_uses_rt : decode sources
//   execute_regfile_write_address / execute_refile_write_en /
//   execute_ram_to_register_en : execute destination and load flag
//   hazard : one-cycle bubble required
module load_use_detector
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] decode_rs_address,
  input  logic [REG_ADDR_W-1:0] decode_rt_address,
  input  logic                  decode_uses_rt,
  input  logic [REG_ADDR_W-1:0] execute_regfile_write_address,
  input  logic                  execute_refile_write_en,
  input  logic                  execute_ram_to_register_en,
  output logic                  hazard
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (execute_regfile_write_address == decode_rs_address);
    rt_match = decode_uses_rt & (execute_regfile_write_address == decode_rt_address);
    hazard   = execute_ram_to_register_en & execute_refile_write_en &
               (execute_regfile_write_address != REG_ZERO) &
               (rs_match | rt_match);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Handles load-use bubbles, taken control transfers resolved in execute,
// and multi-cycle mult/div freezes (start pulse, wait for ready or timeout).
// Control outputs are Mealy functions of state and inputs and are forced
// low while reset is asserted.
// Ports:
//   clock, reset (async, active-low)
//   decode_* / execute_* : hazard sources from decode and the D/X latch
//   multdiv_ready / multdiv_start : mult/div handshake
//   pc_stall, fetch_decode_stall/flush, decode_execute_stall/flush,
//   execute_memory_bubble : pipeline latch controls
//   multdiv_timeout : sticky, a mult/div was released by timeout
//   stall_count : saturating count of cycles with pc_stall=1
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT        = 64,
  parameter int unsigned STALL_COUNT_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [REG_ADDR_W-1:0]        decode_rs_address,
  input  logic [REG_ADDR_W-1:0]        decode_rt_address,
  input  logic                         decode_uses_rt,
  input  logic [REG_ADDR_W-1:0]        execute_regfile_write_address,
  input  logic                         execute_refile_write_en,
  input  logic                         execute_ram_to_register_en,
  input  logic                         execute_branch_taken,
  input  logic                         execute_multdiv_op,
  input  logic                         multdiv_ready,
  output logic                         multdiv_start,
  output logic                         pc_stall,
  output logic                         fetch_decode_stall,
  output logic                         fetch_decode_flush,
  output logic                         decode_execute_stall,
  output logic                         decode_execute_flush,
  output logic                         execute_memory_bubble,
  output logic                         multdiv_timeout,
  output logic [STALL_COUNT_WIDTH-1:0] stall_count
);

  localparam int unsigned MD_CNT_W = $clog2(MD_TIMEOUT + 1);

  ctrl_state_e         state;
  ctrl_state_e         state_next;
  logic [MD_CNT_W-1:0] md_cnt;
  logic                md_at_limit;
  logic                hazard;
  logic                timeout_hit;
  ctrl_bus_t           ctrl;

  load_use_detector u_load_use_detector (
    .decode_rs_address             (decode_rs_address),
    .decode_rt_address             (decode_rt_address),
    .decode_uses_rt                (decode_uses_rt),
    .execute_regfile_write_address (execute_regfile_write_address),
    .execute_refile_write_en       (execute_refile_write_en),
    .execute_ram_to_register_en    (execute_ram_to_register_en),
    .hazard                        (hazard)
  );

  assign md_at_limit = (md_cnt == MD_CNT_W'(MD_TIMEOUT));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (!execute_branch_taken && execute_multdiv_op) begin
          state_next = MD_WAIT;
        end
      end
      MD_WAIT: begin
        if (multdiv_ready || md_at_limit) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Output logic; all controls low while reset is asserted
  always_comb begin
    ctrl        = '0;
    timeout_hit = 1'b0;
    if (reset) begin
      case (state)
        RUN: begin
          if (execute_branch_taken) begin
            // Redirect wins: squash the two younger stages, hazard is moot.
            ctrl.fetch_decode_flush   = 1'b1;
            ctrl.decode_execute_flush = 1'b1;
          end else if (execute_multdiv_op) begin
            ctrl.multdiv_start         = 1'b1;
            ctrl.pc_stall              = 1'b1;
            ctrl.fetch_decode_stall    = 1'b1;
            ctrl.decode_execute_stall  = 1'b1;
            ctrl.execute_memory_bubble = 1'b1;
          end else if (hazard) begin
            ctrl.pc_stall             = 1'b1;
            ctrl.fetch_decode_stall   = 1'b1;
            ctrl.decode_execute_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          // Execute is frozen here, so branch and hazard inputs are stale.
          if (multdiv_ready) begin
            ctrl = '0;
          end else if (md_at_limit) begin
            timeout_hit = 1'b1;
          end else begin
            ctrl.pc_stall              = 1'b1;
            ctrl.fetch_decode_stall    = 1'b1;
            ctrl.decode_execute_stall  = 1'b1;
            ctrl.execute_memory_bubble = 1'b1;
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign multdiv_start         = ctrl.multdiv_start;
  assign pc_stall              = ctrl.pc_stall;
  assign fetch_decode_stall    = ctrl.fetch_decode_stall;
  assign fetch_decode_flush    = ctrl.fetch_decode_flush;
  assign decode_execute_stall  = ctrl.decode_execute_stall;
  assign decode_execute_flush  = ctrl.decode_execute_flush;
  assign execute_memory_bubble = ctrl.execute_memory_bubble;

  // Mult/div wait counter: the start cycle counts as 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (state == RUN && state_next == MD_WAIT) begin
      md_cnt <= MD_CNT_W'(1);
    end else if (state == MD_WAIT && state_next == MD_WAIT) begin
      md_cnt <= md_cnt + MD_CNT_W'(1);
    end else begin
      md_cnt <= '0;
    end
  end

  // Sticky timeout flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      multdiv_timeout <= 1'b0;
    end else if (timeout_hit) begin
      multdiv_timeout <= 1'b1;
    end
  end

  // Saturating stall performance counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (ctrl.pc_stall && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed testbench for pipeline_hazard_controller (MD_TIMEOUT=8,
// 4-bit stall counter so saturation is reachable).
// Control vector order: {start, pc_stall, fd_stall, fd_flush, dx_stall,
// dx_flush, xm_bubble}.
module tb_pipeline_hazard_controller;

  localparam int unsigned TO = 8;
  localparam int unsigned SCW = 4;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_HAZ  = 7'b0110010;
  localparam logic [6:0] C_BR   = 7'b0001010;
  localparam logic [6:0] C_MDS  = 7'b1110101;
  localparam logic [6:0] C_MDW  = 7'b0110101;

  logic           clock;
  logic           reset;
  logic [4:0]     decode_rs_address;
  logic [4:0]     decode_rt_address;
  logic           decode_uses_rt;
  logic [4:0]     execute_regfile_write_address;
  logic           execute_refile_write_en;
  logic           execute_ram_to_register_en;
  logic           execute_branch_taken;
  logic           execute_multdiv_op;
  logic           multdiv_ready;
  logic           multdiv_start;
  logic           pc_stall;
  logic           fetch_decode_stall;
  logic           fetch_decode_flush;
  logic           decode_execute_stall;
  logic           decode_execute_flush;
  logic           execute_memory_bubble;
  logic           multdiv_timeout;
  logic [SCW-1:0] stall_count;
  logic [6:0]     ctl;

  int checks;
  int errors;

  pipeline_hazard_controller #(
    .MD_TIMEOUT        (TO),
    .STALL_COUNT_WIDTH (SCW)
  ) dut (
    .clock                         (clock),
    .reset                         (reset),
    .decode_rs_address             (decode_rs_address),
    .decode_rt_address             (decode_rt_address),
    .decode_uses_rt                (decode_uses_rt),
    .execute_regfile_write_address (execute_regfile_write_address),
    .execute_refile_write_en       (execute_refile_write_en),
    .execute_ram_to_register_en    (execute_ram_to_register_en),
    .execute_branch_taken          (execute_branch_taken),
    .execute_multdiv_op            (execute_multdiv_op),
    .multdiv_ready                 (multdiv_ready),
    .multdiv_start                 (multdiv_start),
    .pc_stall                      (pc_stall),
    .fetch_decode_stall            (fetch_decode_stall),
    .fetch_decode_flush            (fetch_decode_flush),
    .decode_execute_stall          (decode_execute_stall),
    .decode_execute_flush          (decode_execute_flush),
    .execute_memory_bubble         (execute_memory_bubble),
    .multdiv_timeout               (multdiv_timeout),
    .stall_count                   (stall_count)
  );

  assign ctl = {multdiv_start, pc_stall, fetch_decode_stall, fetch_decode_flush,
                decode_execute_stall, decode_execute_flush, execute_memory_bubble};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clr_inputs();
    decode_rs_address             = 5'd0;
    decode_rt_address             = 5'd0;
    decode_uses_rt                = 1'b0;
    execute_regfile_write_address = 5'd0;
    execute_refile_write_en       = 1'b0;
    execute_ram_to_register_en    = 1'b0;
    execute_branch_taken          = 1'b0;
    execute_multdiv_op            = 1'b0;
    multdiv_ready                 = 1'b0;
  endtask

  // Sets a load in execute writing addr, with decode sources rs/rt.
  task automatic set_load(input logic [4:0] addr, input logic [4:0] rs,
                          input logic [4:0] rt, input logic use_rt);
    execute_ram_to_register_en    = 1'b1;
    execute_refile_write_en       = 1'b1;
    execute_regfile_write_address = addr;
    decode_rs_address             = rs;
    decode_rt_address             = rt;
    decode_uses_rt                = use_rt;
  endtask

  task automatic do_reset();
    @(negedge clock);
    clr_inputs();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    set_load(5'd5, 5'd5, 5'd0, 1'b0);
    execute_multdiv_op = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL reset_ctl got %b want %b", ctl, C_NONE);
    end
    @(posedge clock); #1;
    checks++;
    if (stall_count !== 4'd0 || multdiv_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got cnt=%0d to=%b want cnt=0 to=0", stall_count, multdiv_timeout);
    end
    @(negedge clock);
    clr_inputs();
    reset = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    set_load(5'd5, 5'd5, 5'd0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_HAZ) begin
      errors++;
      $display("FAIL load_use_stall got %b want %b", ctl, C_HAZ);
    end
    @(negedge clock);
    execute_regfile_write_address = 5'd0;
    #1;
    checks++;
    if (ctl !== C_NONE || stall_count !== 4'd1) begin
      errors++;
      $display("FAIL load_use_after got ctl=%b cnt=%0d want ctl=%b cnt=1", ctl, stall_count, C_NONE);
    end
  endtask

  task automatic test_filtering();
    do_reset();
    set_load(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL filter_r0 got %b want %b", ctl, C_NONE);
    end
    @(negedge clock);
    set_load(5'd7, 5'd3, 5'd7, 1'b0);
    #1;
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL filter_rt_unused got %b want %b", ctl, C_NONE);
    end
    @(negedge clock);
    set_load(5'd7, 5'd3, 5'd7, 1'b1);
    #1;
    checks++;
    if (ctl !== C_HAZ) begin
      errors++;
      $display("FAIL filter_rt_used got %b want %b", ctl, C_HAZ);
    end
    @(negedge clock);
    set_load(5'd9, 5'd9, 5'd9, 1'b1);
    execute_ram_to_register_en = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL filter_not_load got %b want %b", ctl, C_NONE);
    end
    @(negedge clock);
    set_load(5'd9, 5'd9, 5'd9, 1'b1);
    execute_refile_write_en = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NONE || stall_count !== 4'd1) begin
      errors++;
      $display("FAIL filter_no_wr got ctl=%b cnt=%0d want ctl=%b cnt=1", ctl, stall_count, C_NONE);
    end
  endtask

  task automatic test_branch_over_hazard();
    do_reset();
    set_load(5'd4, 5'd4, 5'd0, 1'b0);
    execute_branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BR) begin
      errors++;
      $display("FAIL branch_ctl got %b want %b", ctl, C_BR);
    end
    @(negedge clock);
    clr_inputs();
    #1;
    checks++;
    if (stall_count !== 4'd0) begin
      errors++;
      $display("FAIL branch_cnt got %0d want 0", stall_count);
    end
  endtask

  task automatic test_multdiv_ready();
    do_reset();
    execute_multdiv_op = 1'b1;
    multdiv_ready      = 1'b1;  // ignored on the start cycle
    #1;
    checks++;
    if (ctl !== C_MDS) begin
      errors++;
      $display("FAIL md_start got %b want %b", ctl, C_MDS);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      multdiv_ready        = 1'b0;
      execute_branch_taken = (k == 2);
      if (k == 2) set_load(5'd6, 5'd6, 5'd0, 1'b0);
      #1;
      checks++;
      if (ctl !== C_MDW) begin
        errors++;
        $display("FAIL md_wait_c%0d got %b want %b", k, ctl, C_MDW);
      end
    end
    @(negedge clock);
    clr_inputs();
    execute_multdiv_op = 1'b1;
    multdiv_ready      = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL md_release got %b want %b", ctl, C_NONE);
    end
    @(negedge clock);
    clr_inputs();
    #1;
    checks++;
    if (ctl !== C_NONE || stall_count !== 4'd4 || multdiv_timeout !== 1'b0) begin
      errors++;
      $display("FAIL md_after got ctl=%b cnt=%0d to=%b want ctl=%b cnt=4 to=0",
               ctl, stall_count, multdiv_timeout, C_NONE);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    execute_multdiv_op = 1'b1;
    #1;
    checks++;
    if (ctl !== C_MDS) begin
      errors++;
      $display("FAIL to_start got %b want %b", ctl, C_MDS);
    end
    for (int k = 1; k < int'(TO); k++) begin
      @(negedge clock);
      #1;
      checks++;
      if (ctl !== C_MDW) begin
        errors++;
        $display("FAIL to_wait_c%0d got %b want %b", k, ctl, C_MDW);
      end
    end
    @(negedge clock);
    #1;
    checks++;
    if (ctl !== C_NONE || multdiv_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_release got ctl=%b to=%b want ctl=%b to=0", ctl, multdiv_timeout, C_NONE);
    end
    // Following normal mult/div, ready on its first wait cycle
    @(negedge clock);
    #1;
    checks++;
    if (ctl !== C_MDS || multdiv_timeout !== 1'b1 || stall_count !== 4'd8) begin
      errors++;
      $display("FAIL to_sticky got ctl=%b to=%b cnt=%0d want ctl=%b to=1 cnt=8",
               ctl, multdiv_timeout, stall_count, C_MDS);
    end
    @(negedge clock);
    multdiv_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL to_second_release got %b want %b", ctl, C_NONE);
    end
    @(negedge clock);
    clr_inputs();
    #1;
    checks++;
    if (multdiv_timeout !== 1'b1 || stall_count !== 4'd9) begin
      errors++;
      $display("FAIL to_second_after got to=%b cnt=%0d want to=1 cnt=9", multdiv_timeout, stall_count);
    end
  endtask

  // Continues from count 9: a full timeout adds 8 stalls, saturating at 15.
  task automatic test_saturation();
    @(negedge clock);
    execute_multdiv_op = 1'b1;
    for (int k = 0; k < int'(TO); k++) @(negedge clock);
    #1;
    checks++;
    if (ctl !== C_NONE || stall_count !== 4'd15) begin
      errors++;
      $display("FAIL sat_timeout got ctl=%b cnt=%0d want ctl=%b cnt=15", ctl, stall_count, C_NONE);
    end
    @(negedge clock);
    clr_inputs();
    set_load(5'd2, 5'd2, 5'd0, 1'b0);
    @(negedge clock);
    clr_inputs();
    #1;
    checks++;
    if (stall_count !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold got %0d want 15", stall_count);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    execute_multdiv_op = 1'b1;
    for (int k = 0; k < 3; k++) @(negedge clock);
    set_load(5'd8, 5'd8, 5'd0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_MDW || stall_count !== 4'd3) begin
      errors++;
      $display("FAIL rmw_before got ctl=%b cnt=%0d want ctl=%b cnt=3", ctl, stall_count, C_MDW);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NONE || stall_count !== 4'd0 || multdiv_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rmw_async got ctl=%b cnt=%0d to=%b want ctl=%b cnt=0 to=0",
               ctl, stall_count, multdiv_timeout, C_NONE);
    end
    @(negedge clock);
    clr_inputs();
    reset         = 1'b1;
    multdiv_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL rmw_ready got %b want %b", ctl, C_NONE);
    end
    @(negedge clock);
    multdiv_ready = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NONE || stall_count !== 4'd0 || multdiv_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rmw_after got ctl=%b cnt=%0d to=%b want ctl=%b cnt=0 to=0",
               ctl, stall_count, multdiv_timeout, C_NONE);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    clr_inputs();
    test_reset();
    test_load_use();
    test_filtering();
    test_branch_over_hazard();
    test_multdiv_ready();
    test_timeout();
    test_saturation();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Watches the decode stage and the decode/execute pipeline latch outputs. Drives stall and flush controls for the PC, the fetch/decode latch, the decode/execute latch and the execute/memory latch.
- Handles three cases: load-use hazards (one-cycle bubble), taken control transfers resolved in execute (flush of two younger stages), and multi-cycle multiply/divide (start handshake plus freeze until the unit reports ready or the timeout expires).

Parameters:
MD_TIMEOUT, 64, maximum stalled cycles for one mult/div operation, start cycle included; must be >= 2
STALL_COUNT_WIDTH, 16, width of the saturating stall performance counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
decode_rs_address  input  5  source register A of the instruction in decode
decode_rt_address  input  5  source register B of the instruction in decode
decode_uses_rt  input  1  decode instruction reads rt
execute_regfile_write_address  input  5  destination register of the instruction in execute
execute_refile_write_en  input  1  execute instruction writes the regfile
execute_ram_to_register_en  input  1  execute instruction is a load
execute_branch_taken  input  1  execute resolved a PC redirect (PC+1+N, PC=T or PC=$rd)
execute_multdiv_op  input  1  execute instruction is a mult/div
multdiv_ready  input  1  mult/div result valid this cycle
multdiv_start  output  1  one-cycle start pulse to the mult/div unit
pc_stall  output  1  hold the PC
fetch_decode_stall  output  1  hold the F/D latch
fetch_decode_flush  output  1  load a nop into the F/D latch
decode_execute_stall  output  1  hold the D/X latch
decode_execute_flush  output  1  load a nop, with all enables 0, into the D/X latch
execute_memory_bubble  output  1  load a nop into the X/M latch
multdiv_timeout  output  1  sticky: a mult/div was released by timeout
stall_count  output  STALL_COUNT_WIDTH  count of cycles with pc_stall=1, saturating at all-ones

Behaviour:
- States: RUN, MD_WAIT. The state register, the wait counter md_cnt (width clog2(MD_TIMEOUT+1)), multdiv_timeout and stall_count are the only flops. All control outputs are combinational from state and inputs (Mealy).
- Reset (reset=0), asynchronous:
  - state=RUN, md_cnt=0, multdiv_timeout=0, stall_count=0.
  - Every control output is forced 0 while reset is asserted.
- hazard = execute_ram_to_register_en & execute_refile_write_en & (execute_regfile_write_address != 0) & ((address == decode_rs_address) | (decode_uses_rt & address == decode_rt_address)).
- RUN priority, highest first:
  1. execute_branch_taken: fetch_decode_flush=1, decode_execute_flush=1, no stalls; hazard ignored. Stay in RUN.
  2. execute_multdiv_op: multdiv_start=1, pc_stall=fetch_decode_stall=decode_execute_stall=1, execute_memory_bubble=1; md_cnt<=1; go to MD_WAIT. multdiv_ready is ignored in this cycle.
  3. hazard: pc_stall=1, fetch_decode_stall=1, decode_execute_flush=1. Stay in RUN. The load leaves execute next cycle, so the bubble is exactly 1 cycle.
  4. Otherwise: all controls 0.
- MD_WAIT:
  - If multdiv_ready: all controls 0 (release), so the X/M latch captures the result; go to RUN.
  - Else if md_cnt == MD_TIMEOUT: release as above, set multdiv_timeout, go to RUN.
  - Else: pc_stall, fetch_decode_stall, decode_execute_stall and execute_memory_bubble stay 1; md_cnt++.
  - execute_branch_taken and hazard are ignored, because execute is frozen.
- Total stalled cycles per mult/div:
  - Ready in MD_WAIT cycle k (start = cycle 0): k stalled cycles.
  - No ready: MD_TIMEOUT stalled cycles.
- multdiv_start never asserts in MD_WAIT and never on the release cycle. On the cycle after release, execute holds the next instruction.
- stall_count increments on every clock edge where pc_stall=1; it holds at 2^STALL_COUNT_WIDTH-1.
- multdiv_timeout is cleared only by reset.
- Reset asserted mid-MD_WAIT: the controller aborts immediately; stalls drop asynchronously; the mult/div unit is reset by the same signal.

Decomposition:
- Shared package pipeline_ctrl_pkg:
  - state encoding (RUN, MD_WAIT)
  - REG_ZERO = 5'd0
  - register-address width constant = 5
- One sub-module: load_use_detector, a pure combinational hazard compare.
- Counters and the FSM stay in the top level.

Test Plan:
- Load-use hazard: exec ram_to_reg=1, wr_en=1, addr=5; decode rs=5 -> in that cycle pc_stall=fetch_decode_stall=decode_execute_flush=1. Next cycle, with exec addr=0, all controls are 0, and stall_count=1.
- Register-zero and rt-unused filtering:
  - Exec load addr=0, rs=0 -> no stall.
  - Exec load addr=7, rt=7, decode_uses_rt=0 -> no stall.
  - Same with decode_uses_rt=1 -> stall.
- Branch over hazard: execute_branch_taken=1 with a hazard active -> fetch_decode_flush=decode_execute_flush=1, pc_stall=0, stall_count unchanged.
- Mult/div with ready: multdiv_op=1 at cycle 0 and multdiv_ready=1 at cycle 4:
  - multdiv_start=1 only in cycle 0.
  - Stalls and bubble are 1 in cycles 0-3 and 0 in cycle 4.
  - State is back in RUN, stall_count=4, multdiv_timeout=0.
- Timeout with MD_TIMEOUT=8 and ready never asserted:
  - Stalls are 1 in cycles 0-7 and released in cycle 8.
  - multdiv_timeout=1 and stays 1 through a following normal mult/div.
- Reset mid-wait: assert reset in MD_WAIT cycle 3:
  - All controls drop to 0 without a clock edge; stall_count=0, timeout=0.
  - After release, a ready pulse causes no action.
